// File: rtl/cache_types_pkg.sv
// Shared types and sizing for the cache line adapter.
package cache_types_pkg;

    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int LINE_W   = BEAT_W * BEATS;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 2;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP
    } adapter_state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory (4 beats per line).
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN drops read beats with a foreign address tag and flags err.
module cacheline_adapter
    import cache_types_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    adapter_state_t    state;
    adapter_state_t    state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rline;
    logic [LINE_W-1:0] rdata_q;

    logic beat_ok;
    logic beat_take;
    logic beat_last;
    logic wr_take;
    logic wr_last;
    logic in_read;

    // Beats may already arrive while the request is still being presented.
    assign in_read = (state == RD_REQ) || (state == RD_DATA);

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    logic err_q;

    assign beat_ok = (bmem_raddr == addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_read && bmem_rvalid && !beat_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign beat_ok = 1'b1;
    // Address tags are not inspected in this build; err folds them into a constant zero.
    assign err     = 1'b0 & (|bmem_raddr);
`endif

    assign beat_take = in_read && bmem_rvalid && beat_ok;
    assign beat_last = beat_take && (cnt == CNT_W'(BEATS - 1));
    assign wr_take   = (state == WR_BURST) && bmem_ready;
    assign wr_last   = wr_take && (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_next = state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_next = WR_BURST;
                end else if (dfp_read) begin
                    state_next = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (beat_last) begin
                    state_next = RESP;
                end else if (bmem_ready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_last) begin
                    state_next = RESP;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wline[BEAT_W-1:0];
                if (wr_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                dfp_resp   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both line registers shift by one beat: reads fill from the top so beat 0
    // ends in [63:0], writes drain from the bottom so the current beat is [63:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wline   <= '0;
            rline   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                cnt <= '0;
                if (dfp_write || dfp_read) begin
                    addr_q <= line_align(dfp_addr);
                end
                if (dfp_write) begin
                    wline <= dfp_wdata;
                end
            end
            if (beat_take) begin
                rline <= {bmem_rdata, rline[LINE_W-1:BEAT_W]};
                cnt   <= cnt + 1'b1;
            end
            if (beat_last) begin
                rdata_q <= {bmem_rdata, rline[LINE_W-1:BEAT_W]};
            end
            if (wr_take) begin
                wline <= {{BEAT_W{1'b0}}, wline[LINE_W-1:BEAT_W]};
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign dfp_rdata = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: bus-level memory model driven from one sequence,
// expected read lines and write beats queued at stimulus time and checked at output.
module tb_cacheline_adapter;
    import cache_types_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [LINE_W-1:0] exp_line_q[$];
    logic [BEAT_W-1:0] exp_beat_q[$];
    logic [LINE_W-1:0] last_line;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check256(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) begin
            l = {l[LINE_W-33:0], 32'($urandom)};
        end
        return l;
    endfunction

    // One line read: request, accept, 4 beats (optional gaps and one foreign-tag beat).
    task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                           input int gap, input int exp_lat, input int bad_at);
        logic [31:0]       al;
        logic [LINE_W-1:0] sh;
        int                lat;
        al        = addr & 32'hFFFF_FFE0;
        dfp_read  = 1'b1;
        dfp_addr  = addr;
        exp_line_q.push_back(line);
        lat = 0;
        do begin
            step();
            lat++;
        end while (bmem_read !== 1'b1 && lat < 10);
        check32("rd_req_latency", lat, exp_lat);
        check1("rd_bmem_read", bmem_read, 1'b1);
        check32("rd_bmem_addr", bmem_addr, al);
        check1("rd_no_write", bmem_write, 1'b0);
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        check1("rd_req_dropped", bmem_read, 1'b0);
        sh = line;
        for (int i = 0; i < BEATS; i++) begin
            if (i == bad_at) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = al ^ 32'h20;
                bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                step();
            end
            for (int g = 0; g < gap; g++) begin
                bmem_rvalid = 1'b0;
                step();
                check1("rd_no_early_resp", dfp_resp, 1'b0);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = al;
            bmem_rdata  = sh[BEAT_W-1:0];
            sh          = sh >> BEAT_W;
            step();
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        check1("rd_resp", dfp_resp, 1'b1);
        if (exp_line_q.size() > 0) begin
            last_line = exp_line_q.pop_front();
            check256("rd_line", dfp_rdata, last_line);
        end
        dfp_read = 1'b0;
        step();
        check1("rd_resp_pulse", dfp_resp, 1'b0);
    endtask

    // One line write-back with bmem_ready following a repeating bit pattern.
    task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                            input logic [7:0] pat, input int patlen, input bit chain);
        logic [31:0]       al;
        logic [LINE_W-1:0] sh;
        int                lat;
        int                cyc;
        int                accepted;
        int                k;
        al        = addr & 32'hFFFF_FFE0;
        dfp_write = 1'b1;
        dfp_addr  = addr;
        dfp_wdata = line;
        sh = line;
        for (int i = 0; i < BEATS; i++) begin
            exp_beat_q.push_back(sh[BEAT_W-1:0]);
            sh = sh >> BEAT_W;
        end
        lat = 0;
        do begin
            step();
            lat++;
        end while (bmem_write !== 1'b1 && lat < 10);
        check32("wr_req_latency", lat, 1);
        check32("wr_bmem_addr", bmem_addr, al);
        check1("wr_no_read", bmem_read, 1'b0);
        accepted = 0;
        k        = 0;
        cyc      = 0;
        while (accepted < BEATS && cyc < 40) begin
            bmem_ready = pat[k % patlen];
            k++;
            check1("wr_valid", bmem_write, 1'b1);
            if (exp_beat_q.size() > 0) begin
                check64("wr_beat", bmem_wdata, exp_beat_q[0]);
            end
            if (bmem_ready) begin
                accepted++;
                if (exp_beat_q.size() > 0) begin
                    void'(exp_beat_q.pop_front());
                end
            end
            step();
            cyc++;
        end
        bmem_ready = 1'b0;
        check1("wr_resp", dfp_resp, 1'b1);
        check1("wr_write_dropped", bmem_write, 1'b0);
        check256("wr_rdata_kept", dfp_rdata, last_line);
        dfp_write = 1'b0;
        if (!chain) begin
            step();
            check1("wr_resp_pulse", dfp_resp, 1'b0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        last_line   = '0;
        repeat (3) step();
        rst = 1'b0;

        check256("reset_rdata", dfp_rdata, '0);
        check1("reset_resp", dfp_resp, 1'b0);
        check32("reset_bmem_addr", bmem_addr, '0);
        check1("reset_bmem_read", bmem_read, 1'b0);
        check1("reset_bmem_write", bmem_write, 1'b0);
        check64("reset_bmem_wdata", bmem_wdata, '0);
        check1("reset_err", err, 1'b0);

        // Basic read with unaligned address.
        do_read(32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1, -1);

        // Write with ready pattern 1,0,1,1,0,1.
        do_write(32'h0000_2000,
                 {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                  64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}, 8'h2D, 6, 1'b0);

        // Write-back then allocate, request handed over in the RESP cycle.
        do_write(32'h8000_0040, rand_line(), 8'h01, 1, 1'b1);
        do_read(32'h0000_0040, rand_line(), $urandom_range(0, 2), 2, -1);

        // Reset two beats into a read.
        dfp_read = 1'b1;
        dfp_addr = 32'h0000_0080;
        step();
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_0080;
            bmem_rdata  = 64'(32'($urandom));
            step();
        end
        bmem_rvalid = 1'b0;
        rst         = 1'b1;
        dfp_read    = 1'b0;
        step();
        rst       = 1'b0;
        last_line = '0;
        check1("abort_resp", dfp_resp, 1'b0);
        check1("abort_bmem_read", bmem_read, 1'b0);
        check256("abort_rdata", dfp_rdata, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check1("abort_no_stale_resp", dfp_resp, 1'b0);
        end
        do_read(32'h0000_0040, rand_line(), 1, 1, -1);

        // Stray beats in IDLE, then read and write requested together.
        for (int i = 0; i < 3; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_0100;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            check1("stray_no_resp", dfp_resp, 1'b0);
            check1("stray_no_read", bmem_read, 1'b0);
        end
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b1;
        do_write(32'h0000_0300, rand_line(), 8'h06, 3, 1'b1);
        do_read(32'h0000_0300, rand_line(), 0, 2, -1);

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        check1("err_clear_before", err, 1'b0);
        do_read(32'h0000_0040, rand_line(), 0, 1, 2);
        check1("err_sticky", err, 1'b1);
        repeat (2) step();
        check1("err_held", err, 1'b1);
`else
        check1("err_tied_low", err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
